// File: rtl/reg_write_sched.sv
// Register-file write-port scheduler: arbitrates control-unit (A) and
// memory-load (B) writers and sequences single or burst register writes.
module reg_write_sched #(
   parameter int NREG = 19,
   parameter int AW   = 5,
   parameter int LW   = 2
) (
   input  logic            Clock,
   input  logic            Reset_n,
   input  logic            reqA,
   input  logic [AW-1:0]   addrA,
   input  logic [LW-1:0]   lenA,
   input  logic            reqB,
   input  logic [AW-1:0]   addrB,
   input  logic [LW-1:0]   lenB,
   output logic            gntA,
   output logic            gntB,
   output logic            doneA,
   output logic            doneB,
   output logic [NREG-1:0] wr_en,
   output logic            busy,
   output logic            err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [AW-1:0] BCAST = '1;
   localparam logic [AW-1:0] LASTC = AW'(NREG);

   function automatic logic [NREG-1:0] dec(input logic [AW-1:0] c);
      logic [NREG-1:0] d;
      d = '0;
      if (c == BCAST) begin
         d = '1;
      end else begin
         for (int k = 0; k < NREG; k++) begin
            d[k] = (c == AW'(k + 1));
         end
      end
      return d;
   endfunction

   function automatic logic illegal(input logic [AW-1:0] c);
      return (c != BCAST) && ((c == '0) || (c > LASTC));
   endfunction

   state_t          state_q, state_d;
   logic            own_q, own_d;
   logic            last_q, last_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [LW-1:0]   len_q, len_d;
   logic [LW-1:0]   cnt_q, cnt_d;
   logic            gntA_d, gntB_d;
   logic            doneA_d, doneB_d;
   logic [NREG-1:0] wr_d;
   logic            err_d;

   logic            req_own;
   logic            pick_b;
   logic [AW-1:0]   addr_sel;
   logic [AW-1:0]   addr_nxt;

   assign req_own  = own_q ? reqB : reqA;
   // last_q = 1 means B was served last, so A wins a tie
   assign pick_b   = reqB && (!reqA || !last_q);
   assign addr_sel = pick_b ? addrB : addrA;
   assign addr_nxt = (addr_q == LASTC) ? AW'(1) : addr_q + AW'(1);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (reqA || reqB) state_d = WRITE;
         end
         WRITE: begin
            if (!req_own) begin
               state_d = IDLE;
            end else if (cnt_q == len_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      own_d   = own_q;
      last_d  = last_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      gntA_d  = gntA;
      gntB_d  = gntB;
      doneA_d = 1'b0;
      doneB_d = 1'b0;
      wr_d    = '0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (reqA || reqB) begin
               own_d  = pick_b;
               last_d = pick_b;
               addr_d = addr_sel;
               // broadcast collapses any burst to one write
               if (addr_sel == BCAST) begin
                  len_d = '0;
               end else begin
                  len_d = pick_b ? lenB : lenA;
               end
               cnt_d  = '0;
               gntA_d = !pick_b;
               gntB_d = pick_b;
               wr_d   = dec(addr_sel);
               err_d  = illegal(addr_sel);
            end
         end
         WRITE: begin
            if (!req_own) begin
               gntA_d = 1'b0;
               gntB_d = 1'b0;
            end else if (cnt_q == len_q) begin
               doneA_d = !own_q;
               doneB_d = own_q;
            end else begin
               addr_d = addr_nxt;
               cnt_d  = cnt_q + LW'(1);
               wr_d   = dec(addr_nxt);
               err_d  = illegal(addr_nxt);
            end
         end
         DONE: begin
            gntA_d = 1'b0;
            gntB_d = 1'b0;
         end
         default: begin
            gntA_d = 1'b0;
            gntB_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         own_q  <= 1'b0;
         last_q <= 1'b1;
         addr_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
         gntA   <= 1'b0;
         gntB   <= 1'b0;
         doneA  <= 1'b0;
         doneB  <= 1'b0;
         wr_en  <= '0;
         err    <= 1'b0;
         busy   <= 1'b0;
      end else begin
         own_q  <= own_d;
         last_q <= last_d;
         addr_q <= addr_d;
         len_q  <= len_d;
         cnt_q  <= cnt_d;
         gntA   <= gntA_d;
         gntB   <= gntB_d;
         doneA  <= doneA_d;
         doneB  <= doneB_d;
         wr_en  <= wr_d;
         err    <= err_d;
         busy   <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_reg_write_sched.sv
// Directed bench for reg_write_sched: single, burst wrap, tie
// alternation, broadcast/illegal codes, abort and async reset.
module tb_reg_write_sched;

   typedef logic [24:0] ov_t;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic        reqA, reqB;
   logic [4:0]  addrA, addrB;
   logic [1:0]  lenA, lenB;
   logic        gntA, gntB, doneA, doneB, busy, err;
   logic [18:0] wr_en;

   int tests = 0;
   int fails = 0;

   always #5 Clock = ~Clock;

   reg_write_sched dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .reqA    (reqA),
      .addrA   (addrA),
      .lenA    (lenA),
      .reqB    (reqB),
      .addrB   (addrB),
      .lenB    (lenB),
      .gntA    (gntA),
      .gntB    (gntB),
      .doneA   (doneA),
      .doneB   (doneB),
      .wr_en   (wr_en),
      .busy    (busy),
      .err     (err)
   );

   // {gntA,gntB,doneA,doneB,busy,err,wr_en}
   function automatic ov_t obs();
      return {gntA, gntB, doneA, doneB, busy, err, wr_en};
   endfunction

   function automatic ov_t ov(input logic [5:0] f, input logic [18:0] w);
      return {f, w};
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle_inputs();
      reqA  = 1'b0;
      reqB  = 1'b0;
      addrA = 5'd0;
      addrB = 5'd0;
      lenA  = 2'd0;
      lenB  = 2'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      Reset_n = 1'b0;
      tick();
      tick();
      Reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if (obs() !== ov(6'b000000, 19'h0)) begin
         fails++;
         $display("FAIL reset: got %h want %h", obs(), ov(6'b000000, 19'h0));
      end
      tick();
      tests++;
      if (obs() !== ov(6'b000000, 19'h0)) begin
         fails++;
         $display("FAIL reset_idle: got %h want %h", obs(), ov(6'b000000, 19'h0));
      end
   endtask

   task automatic test_single();
      ov_t e[3];
      e = '{ov(6'b100010, 19'h4), ov(6'b101010, 19'h0), ov(6'b000000, 19'h0)};
      reqA  = 1'b1;
      addrA = 5'd3;
      lenA  = 2'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (obs() !== e[i]) begin
            fails++;
            $display("FAIL single[%0d]: got %h want %h", i, obs(), e[i]);
         end
         if (i == 1) reqA = 1'b0;
      end
   endtask

   task automatic test_burst_wrap();
      ov_t e[6];
      e = '{ov(6'b010010, 19'h20000), ov(6'b010010, 19'h40000),
            ov(6'b010010, 19'h00001), ov(6'b010010, 19'h00002),
            ov(6'b010110, 19'h0),     ov(6'b000000, 19'h0)};
      reqB  = 1'b1;
      addrB = 5'd18;
      lenB  = 2'd3;
      for (int i = 0; i < 6; i++) begin
         tick();
         tests++;
         if (obs() !== e[i]) begin
            fails++;
            $display("FAIL burst[%0d]: got %h want %h", i, obs(), e[i]);
         end
         if (i == 4) reqB = 1'b0;
      end
   endtask

   task automatic test_tie();
      ov_t e[6];
      e = '{ov(6'b100010, 19'h10), ov(6'b101010, 19'h0),
            ov(6'b000000, 19'h0),  ov(6'b010010, 19'h40),
            ov(6'b010110, 19'h0),  ov(6'b000000, 19'h0)};
      do_reset();
      for (int r = 0; r < 2; r++) begin
         reqA  = 1'b1;
         reqB  = 1'b1;
         addrA = 5'd5;
         addrB = 5'd7;
         lenA  = 2'd0;
         lenB  = 2'd0;
         for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (obs() !== e[i]) begin
               fails++;
               $display("FAIL tie[%0d][%0d]: got %h want %h", r, i, obs(), e[i]);
            end
            if (i == 1) reqA = 1'b0;
            if (i == 4) reqB = 1'b0;
         end
      end
   endtask

   task automatic test_bcast_illegal();
      ov_t eb[3];
      ov_t ez[3];
      ov_t ei[4];
      eb = '{ov(6'b100010, 19'h7FFFF), ov(6'b101010, 19'h0), ov(6'b000000, 19'h0)};
      ez = '{ov(6'b100011, 19'h0), ov(6'b101010, 19'h0), ov(6'b000000, 19'h0)};
      ei = '{ov(6'b100011, 19'h0), ov(6'b100011, 19'h0),
             ov(6'b101010, 19'h0), ov(6'b000000, 19'h0)};
      reqA  = 1'b1;
      addrA = 5'd31;
      lenA  = 2'd2;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (obs() !== eb[i]) begin
            fails++;
            $display("FAIL bcast[%0d]: got %h want %h", i, obs(), eb[i]);
         end
         if (i == 1) reqA = 1'b0;
      end
      reqA  = 1'b1;
      addrA = 5'd0;
      lenA  = 2'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (obs() !== ez[i]) begin
            fails++;
            $display("FAIL code0[%0d]: got %h want %h", i, obs(), ez[i]);
         end
         if (i == 1) reqA = 1'b0;
      end
      reqA  = 1'b1;
      addrA = 5'd20;
      lenA  = 2'd1;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++;
         if (obs() !== ei[i]) begin
            fails++;
            $display("FAIL code20[%0d]: got %h want %h", i, obs(), ei[i]);
         end
         if (i == 2) reqA = 1'b0;
      end
   endtask

   task automatic test_abort_reset();
      ov_t ea[4];
      ov_t et[3];
      ea = '{ov(6'b100010, 19'h1), ov(6'b100010, 19'h2),
             ov(6'b000000, 19'h0), ov(6'b000000, 19'h0)};
      et = '{ov(6'b010010, 19'h8), ov(6'b010110, 19'h0), ov(6'b000000, 19'h0)};
      reqA  = 1'b1;
      addrA = 5'd1;
      lenA  = 2'd3;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++;
         if (obs() !== ea[i]) begin
            fails++;
            $display("FAIL abort[%0d]: got %h want %h", i, obs(), ea[i]);
         end
         if (i == 1) reqA = 1'b0;
      end
      // aborted A counts as last served, so B wins this tie
      reqA  = 1'b1;
      reqB  = 1'b1;
      addrA = 5'd2;
      addrB = 5'd4;
      lenA  = 2'd0;
      lenB  = 2'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (obs() !== et[i]) begin
            fails++;
            $display("FAIL abort_tie[%0d]: got %h want %h", i, obs(), et[i]);
         end
         if (i == 1) begin
            reqA = 1'b0;
            reqB = 1'b0;
         end
      end
      reqA  = 1'b1;
      addrA = 5'd1;
      lenA  = 2'd3;
      tick();
      tests++;
      if (obs() !== ov(6'b100010, 19'h1)) begin
         fails++;
         $display("FAIL rst_pre: got %h want %h", obs(), ov(6'b100010, 19'h1));
      end
      #1;
      Reset_n = 1'b0;
      #1;
      tests++;
      if (obs() !== ov(6'b000000, 19'h0)) begin
         fails++;
         $display("FAIL rst_async: got %h want %h", obs(), ov(6'b000000, 19'h0));
      end
      idle_inputs();
      tick();
      Reset_n = 1'b1;
      reqA  = 1'b1;
      reqB  = 1'b1;
      addrA = 5'd19;
      addrB = 5'd4;
      tick();
      tests++;
      if (obs() !== ov(6'b100010, 19'h40000)) begin
         fails++;
         $display("FAIL rst_ptr: got %h want %h", obs(), ov(6'b100010, 19'h40000));
      end
      reqB = 1'b0;
      tick();
      tests++;
      if (obs() !== ov(6'b101010, 19'h0)) begin
         fails++;
         $display("FAIL rst_done: got %h want %h", obs(), ov(6'b101010, 19'h0));
      end
      reqA = 1'b0;
      tick();
   endtask

   initial begin
      Reset_n = 1'b0;
      idle_inputs();
      test_reset();
      test_single();
      test_burst_wrap();
      test_tie();
      test_bcast_illegal();
      test_abort_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
